wptr_full_ctrl: RTL and testbench
=================================

Name: wptr_full_ctrl

Overview:
- Write-domain pointer and full-flag generator for the asynchronous FIFO.
- Keeps the binary write address and the Gray-coded write pointer.
- The Gray write pointer feeds the read-domain synchronizer.
- Consumes the read pointer after its 2-flop synchronization into the write clock, and produces full, a write-enable for the RAM, a fill level and a sticky overflow flag.

Parameters:
- ADDR_WIDTH, 6, RAM address bits. FIFO depth = 2**ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits, matching the synchronizer WIDTH.
- AF_THRESH, 2**ADDR_WIDTH-4, almost_full threshold. Only used when ALMOST_FULL_EN is defined.

Ports:
- clk  input  1  write-domain clock.
- rstn  input  1  asynchronous active-low reset.
- winc  input  1  write request from producer.
- rptr_sync  input  ADDR_WIDTH+1  Gray read pointer, already synchronized into clk.
- wen  output  1  RAM write strobe. Combinational: winc & ~full.
- waddr  output  ADDR_WIDTH  RAM write address. Equals wbin[ADDR_WIDTH-1:0].
- wptr  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-side synchronizer.
- full  output  1  registered FIFO-full flag.
- wlevel  output  ADDR_WIDTH+1  registered fill level as seen from the write domain.
- overflow  output  1  sticky flag: a write was attempted while full.
- almost_full  output  1  only present with ALMOST_FULL_EN.

Behaviour:
- Reset (async assert on rstn=0, sync release): wbin=0, wptr=0, full=0, wlevel=0, overflow=0, almost_full=0. All outputs hold at 0 while rstn=0.
- Internal registers: wbin (ADDR_WIDTH+1 bits binary), wptr (Gray), full, wlevel, overflow.
- Accept rule: a write is accepted in a cycle where winc=1 and full=0. wen mirrors this in the same cycle, and waddr addresses the current slot.
- On an accepted write:
  - wbin_next = wbin+1, modulo 2**(ADDR_WIDTH+1), so the pointer wraps naturally.
  - Otherwise wbin_next = wbin.
  - wgray_next = wbin_next ^ (wbin_next>>1).
  - wptr and wbin update on the next clk edge. One cycle of latency from write to the wptr change.
- Full:
  - full_next = (wgray_next == {~rptr_sync[MSB:MSB-1], rptr_sync[MSB-2:0]}).
  - Registered, so full rises on the edge that accepts the write filling the last slot.
- Full release is pessimistic: full drops no earlier than the first clk edge after rptr_sync changes. This is ≥2 clk after the read-side pointer moves; this is required and safe.
- wlevel:
  - rbin = Gray-to-binary(rptr_sync).
  - wlevel_next = wbin_next - rbin, in ADDR_WIDTH+1 bits, unsigned modular.
  - Range 0..2**ADDR_WIDTH. wlevel = 2**ADDR_WIDTH exactly when full_next=1.
- Overflow:
  - winc=1 while full=1 sets overflow on the next edge.
  - The write is dropped: wen=0, pointers unchanged.
  - overflow is cleared only by reset.
- Simultaneous events:
  - A write and a read-pointer advance in the same cycle are both reflected in full_next and wlevel_next.
  - A write accepted in the cycle full deasserts is legal.
- Reset mid-operation: all state clears immediately. The read side must be reset concurrently; this block does not coordinate that.

Optional Feature:
- Macro ALMOST_FULL_EN.
- Defined: almost_full port exists, registered, almost_full_next = (wlevel_next >= AF_THRESH), reset 0.
- Undefined: the port and its logic are absent, and AF_THRESH is unused.

Decomposition:
- Package async_fifo_pkg:
  - function bin2gray.
  - function gray2bin, loop XOR-reduce.
  - PTR_W = ADDR_WIDTH+1 convention.
- Sub-module gray_to_bin: parameterized combinational converter for rptr_sync. The read-side counterpart reuses it.

Test Plan:
- Reset: ADDR_WIDTH=3, hold rstn=0 with winc=1 → wptr=0, waddr=0, full=0, wlevel=0, overflow=0, wen=0.
- Fill: rptr_sync=0, winc=1 for 8 cycles → waddr 0..7, wptr Gray 0,1,3,2,6,7,5,4 then 12. full=1 and wlevel=8 after the 8th edge.
- Overflow: full=1, winc=1 for 3 cycles → wen=0, wptr stays 4'b1100, overflow=1 and stays 1 until rstn pulse.
- Release: full; drive rptr_sync 0→1 (Gray) → full=0 and wlevel=7 on the next edge. One more write → full=1 again, wptr=4'b1101.
- Wrap: after 16 writes with matching reads → wbin wraps to 0, wptr=0, full never asserts, wlevel stays ≤1.
- ALMOST_FULL_EN with AF_THRESH=6: write 5 → almost_full=0. 6th write → almost_full=1 on the same edge that wlevel becomes 6.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the asynchronous FIFO: Gray/binary conversion.
// Pointers are PTR_W = ADDR_WIDTH+1 bits wide; callers size-cast the 32-bit results.
package async_fifo_pkg;

    localparam int CONV_W = 32;

    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
        logic [CONV_W-1:0] b;
        b[CONV_W-1] = g[CONV_W-1];
        for (int i = CONV_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter, shared by the read and write pointer blocks.
module gray_to_bin
    import async_fifo_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin = WIDTH'(gray2bin(CONV_W'(gray)));

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer, full flag, fill level and sticky overflow for the async FIFO.
// Optional almost_full output is built when ALMOST_FULL_EN is defined.
module wptr_full_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int AF_THRESH  = 2**ADDR_WIDTH - 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_sync,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   wlevel,
`ifdef ALMOST_FULL_EN
    output logic                  almost_full,
`endif
    output logic                  overflow
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    if (AF_THRESH < 0 || AF_THRESH > 2**ADDR_WIDTH) begin : g_bad_af_thresh
        $error("AF_THRESH must lie within 0..2**ADDR_WIDTH");
    end

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] wlevel_next;
    logic             full_next;

    gray_to_bin #(
        .WIDTH (PTR_W)
    ) u_rptr_bin (
        .gray (rptr_sync),
        .bin  (rbin)
    );

    // RAM writes are also blocked while reset is asserted.
    assign wen   = winc & ~full & rstn;
    assign waddr = wbin[ADDR_WIDTH-1:0];

    assign wbin_next   = wbin + PTR_W'(wen);
    assign wgray_next  = PTR_W'(bin2gray(CONV_W'(wbin_next)));
    assign wlevel_next = wbin_next - rbin;

    // Full when write pointer has lapped the read pointer: top two Gray bits inverted.
    assign full_next = (wgray_next == {~rptr_sync[PTR_W-1:PTR_W-2], rptr_sync[PTR_W-3:0]});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wbin     <= '0;
            wptr     <= '0;
            full     <= 1'b0;
            wlevel   <= '0;
            overflow <= 1'b0;
        end else begin
            wbin   <= wbin_next;
            wptr   <= wgray_next;
            full   <= full_next;
            wlevel <= wlevel_next;
            if (winc && full) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef ALMOST_FULL_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (CONV_W'(wlevel_next) >= CONV_W'(AF_THRESH));
        end
    end
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Scoreboard bench for wptr_full_ctrl (ADDR_WIDTH=3); the model counts writes/reads as integers.
module tb_wptr_full_ctrl;

    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 8;
    localparam int AFT   = 6;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          winc = 1'b0;
    logic [PW-1:0] rptr_sync = '0;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr;
    logic          full;
    logic [PW-1:0] wlevel;
    logic          overflow;
`ifdef ALMOST_FULL_EN
    logic          almost_full;
`endif

    always #5 clk = ~clk;

    wptr_full_ctrl #(
        .ADDR_WIDTH (AW),
        .AF_THRESH  (AFT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .winc        (winc),
        .rptr_sync   (rptr_sync),
        .wen         (wen),
        .waddr       (waddr),
        .wptr        (wptr),
        .full        (full),
        .wlevel      (wlevel),
`ifdef ALMOST_FULL_EN
        .almost_full (almost_full),
`endif
        .overflow    (overflow)
    );

    typedef struct {
        int wen;
        int waddr;
        int wptr;
        int wlevel;
        int full;
        int ovf;
        int af;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: total accepted writes and the read count currently visible.
    int wr_tot = 0;
    int rd_tot = 0;
    int m_full = 0;
    int m_ovf  = 0;
    int m_af   = 0;

    function automatic int gray(int v);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input int r, input int w, input int adv);
        exp_t e;
        int   rd_new;
        int   acc;
        @(posedge clk);
        #1;
        rstn = r[0];
        winc = w[0];
        if (r == 0) begin
            wr_tot = 0; rd_tot = 0; m_full = 0; m_ovf = 0; m_af = 0;
            rptr_sync = '0;
            e = '{0, 0, 0, 0, 0, 0, 0};
            q.push_back(e);
            return;
        end
        rd_new = rd_tot + adv;
        if (rd_new > wr_tot) rd_new = wr_tot;
        rptr_sync = PW'(gray(rd_new % 16));
        e.wptr   = gray(wr_tot % 16);
        e.wlevel = wr_tot - rd_tot;
        e.full   = m_full;
        e.ovf    = m_ovf;
        e.af     = m_af;
        acc      = (w != 0 && m_full == 0) ? 1 : 0;
        e.wen    = acc;
        e.waddr  = wr_tot % DEPTH;
        q.push_back(e);
        if (w != 0 && m_full != 0) m_ovf = 1;
        wr_tot += acc;
        rd_tot  = rd_new;
        m_full  = ((wr_tot - rd_tot) == DEPTH) ? 1 : 0;
        m_af    = ((wr_tot - rd_tot) >= AFT) ? 1 : 0;
    endtask

    // Monitor: compares every scoreboard entry at the falling edge of its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("wen",      int'(wen),      e.wen);
                check("waddr",    int'(waddr),    e.waddr);
                check("wptr",     int'(wptr),     e.wptr);
                check("wlevel",   int'(wlevel),   e.wlevel);
                check("full",     int'(full),     e.full);
                check("overflow", int'(overflow), e.ovf);
`ifdef ALMOST_FULL_EN
                check("almost_full", int'(almost_full), e.af);
`endif
            end
        end
    end

    initial begin
        #2 rstn = 1'b0;
        // Reset held with winc high
        repeat (3) drive(0, 1, 0);
        // Fill 8 slots with no reads, then attempt writes while full
        repeat (8) drive(1, 1, 0);
        repeat (3) drive(1, 1, 0);
        drive(1, 0, 0);
        // One read releases full; one write refills
        drive(1, 0, 1);
        drive(1, 1, 0);
        drive(1, 0, 0);
        // Reset, then matched write/read stream across the pointer wrap
        repeat (2) drive(0, 0, 0);
        repeat (20) drive(1, 1, 1);
        drive(1, 0, 1);
        // Random mix biased toward writes so full and overflow recur
        for (int i = 0; i < 300; i++) begin
            drive(1, ($urandom_range(0, 9) < 7) ? 1 : 0, ($urandom_range(0, 3) == 0) ? 1 : 0);
        end
        drive(0, 1, 0);
        // Random mix biased toward reads, with occasional multi-slot pointer jumps
        for (int i = 0; i < 300; i++) begin
            drive(1, ($urandom_range(0, 9) < 5) ? 1 : 0, $urandom_range(0, 2));
        end
        drive(1, 0, 0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) check("drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
